// File: rtl/bcd7_pkg.sv
// bcd7_pkg: shared digit-select types and constants for bcd7 and bcd7_scan
package bcd7_pkg;
  localparam int DIGITS = 4;
  typedef logic [DIGITS-1:0] an_t;
  typedef logic [1:0] digit_idx_t;
  localparam an_t AN_RESET = 4'b1000;
  localparam an_t AN_OFF_N = 4'b1111;
endpackage

// File: rtl/bcd7_scan_prescaler.sv
// scan_prescaler: free-running power-of-two prescaler with a wrap strobe on all-ones
module scan_prescaler #(
  parameter int DIV_LOG2 = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [DIV_LOG2-1:0] cnt,
  output logic                wrap
);
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  always_comb cnt_d = reset ? '0 : en ? cnt_q + DIV_LOG2'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign cnt  = cnt_q;
  assign wrap = en & (&cnt_q);
endmodule

// File: rtl/bcd7_scan.sv
// bcd7_scan: 4-digit one-hot scan driver with active-low anode drive.
// Define BCD7_SCAN_DIM_EN to enable duty-based PWM dimming of the anodes.
module bcd7_scan
  import bcd7_pkg::*;
#(
  parameter int DIV_LOG2 = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] duty,
  output an_t        an,
  output an_t        an_n,
  output digit_idx_t digit_idx,
  output logic       tick
);
  logic [DIV_LOG2-1:0] cnt;
  logic wrap, vis;
  an_t an_q, an_d, an_n_q, an_n_d;
  digit_idx_t idx_q, idx_d;
  logic tick_q, tick_d;
  scan_prescaler #(.DIV_LOG2(DIV_LOG2)) u_pre (
    .clk  (clk),
    .reset(reset),
    .en   (scan_en),
    .cnt  (cnt),
    .wrap (wrap)
  );
`ifdef BCD7_SCAN_DIM_EN
  logic [DIV_LOG2-1:0] cnt_nx;
  assign cnt_nx = scan_en ? cnt + DIV_LOG2'(1) : cnt;
  assign vis    = scan_en & (cnt_nx[DIV_LOG2-1 -: 4] <= duty);
`else
  // duty and cnt only shape the anode drive when dimming is built in
  assign vis = scan_en | (1'b0 & ^{duty, cnt});
`endif
  always_comb begin
    an_d   = reset ? AN_RESET : wrap ? {an_q[0], an_q[DIGITS-1:1]} : an_q;
    idx_d  = reset ? 2'd3 : wrap ? idx_q - 2'd1 : idx_q;
    tick_d = ~reset & wrap;
    an_n_d = reset ? AN_OFF_N : ~(an_d & {DIGITS{vis}});
  end
  always_ff @(posedge clk) begin
    an_q   <= an_d;
    idx_q  <= idx_d;
    tick_q <= tick_d;
    an_n_q <= an_n_d;
  end
  assign an        = an_q;
  assign an_n      = an_n_q;
  assign digit_idx = idx_q;
  assign tick      = tick_q;
endmodule

// File: tb/tb_bcd7_scan.sv
// tb_bcd7_scan: directed self-checking bench for bcd7_scan with a 16-cycle slot
module tb_bcd7_scan;
  logic clk = 0, reset, scan_en;
  logic [3:0] duty, an, an_n;
  logic [1:0] digit_idx;
  logic tick;
  int checks = 0, errors = 0, ticks = 0;

  bcd7_scan #(.DIV_LOG2(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .scan_en  (scan_en),
    .duty     (duty),
    .an       (an),
    .an_n     (an_n),
    .digit_idx(digit_idx),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(string tag, logic [3:0] e_an, logic [1:0] e_idx, logic e_tick, logic [3:0] e_an_n);
    chk({tag, ".an"}, an, e_an);
    chk({tag, ".idx"}, {2'b0, digit_idx}, {2'b0, e_idx});
    chk({tag, ".tick"}, {3'b0, tick}, {3'b0, e_tick});
    chk({tag, ".an_n"}, an_n, e_an_n);
  endtask

  initial begin
    logic [3:0] e_an;
    int d;
    reset = 1;
    scan_en = 0;
`ifdef BCD7_SCAN_DIM_EN
    duty = 4'd15;
`else
    duty = 4'd0;
`endif
    step();
    step();
    chk_all("rst", 4'b1000, 2'd3, 1'b0, 4'b1111);
    reset = 0;
    step();
    chk_all("idle", 4'b1000, 2'd3, 1'b0, 4'b1111);
    scan_en = 1;
    for (int k = 1; k <= 64; k++) begin
      step();
      d = (k / 16) % 4;
      e_an = 4'b1000 >> d;
      chk_all("scan", e_an, 2'(3 - d), k % 16 == 0, ~e_an);
      if (tick) ticks++;
    end
    chk("tick_count", 4'(ticks), 4'd4);
    repeat (23) step();
    chk("pre_freeze.an", an, 4'b0100);
    chk("pre_freeze.cnt", dut.u_pre.cnt_q, 4'd7);
    scan_en = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all("frozen", 4'b0100, 2'd2, 1'b0, 4'b1111);
    end
    chk("frozen.cnt", dut.u_pre.cnt_q, 4'd7);
    scan_en = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all("resume", 4'b0100, 2'd2, 1'b0, 4'b1011);
    end
    step();
    chk_all("resume_adv", 4'b0010, 2'd1, 1'b1, 4'b1101);
    repeat (5) step();
    reset = 1;
    step();
    chk_all("midrst", 4'b1000, 2'd3, 1'b0, 4'b1111);
    chk("midrst.cnt", dut.u_pre.cnt_q, 4'd0);
    reset = 0;
    step();
    chk_all("post_rst", 4'b1000, 2'd3, 1'b0, 4'b0111);
    repeat (14) step();
    chk_all("post_rst_hold", 4'b1000, 2'd3, 1'b0, 4'b0111);
    step();
    chk_all("post_rst_adv", 4'b0100, 2'd2, 1'b1, 4'b1011);
`ifdef BCD7_SCAN_DIM_EN
    duty = 4'd3;
    for (int k = 1; k <= 16; k++) begin
      step();
      e_an = (k == 16) ? 4'b0010 : 4'b0100;
      chk("dim3.an_n", an_n, ((k % 16) <= 3) ? ~e_an : 4'b1111);
    end
    duty = 4'd15;
    for (int k = 1; k <= 16; k++) begin
      step();
      e_an = (k == 16) ? 4'b0001 : 4'b0010;
      chk("dim15.an_n", an_n, ~e_an);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd7_scan.md
Name: bcd7_scan

Overview:
- Digit-scan driver directly upstream of the bcd7 segment decoder on the bus.
- Generates the one-hot digit select `an` that bcd7 uses to pick a nibble of its latched 16-bit value.
- Generates the active-low anode drive for the board's 4-digit common-anode display.
- Time-multiplexes the four digits at a refresh rate derived from the system clock by a power-of-two prescaler.

Parameters:
- DIV_LOG2, 16: prescaler width. Each digit is shown for 2**DIV_LOG2 clk cycles. Legal range 4..24.

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset.
- scan_en  input  1  1 = scanning runs; 0 = freeze scan and blank the display.
- duty  input  4  brightness level 0..15. Used only when BCD7_SCAN_DIM_EN is defined; ignored otherwise.
- an  output  4  one-hot active-high digit select to bcd7. Legal values 1000, 0100, 0010, 0001.
- an_n  output  4  active-low anode drive to the pins. 1111 = all digits off.
- digit_idx  output  2  index of the selected digit. 3 for 1000, 0 for 0001.
- tick  output  1  one-cycle pulse, high in the cycle after `an` advances.

Behaviour:
- All outputs are registered. Reset is sampled only on posedge clk. Reset wins over every other input.
- Reset values:
  - cnt = 0
  - an = 4'b1000
  - digit_idx = 3
  - tick = 0
  - an_n = 4'b1111
- Prescaler cnt [DIV_LOG2-1:0]:
  - Increments by 1 every cycle while scan_en=1.
  - Wraps naturally from all-ones to 0.
  - Holds its value while scan_en=0.
- Advance condition: scan_en=1 and cnt = all-ones. In the next cycle:
  - `an` rotates right: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
  - digit_idx decrements mod 4 (3 -> 2 -> 1 -> 0 -> 3).
  - tick = 1. tick is 0 in every other cycle.
- Visibility vis:
  - Without the optional feature: vis = scan_en.
  - The registered output is an_n <= ~(an_next & {4{vis}}), where an_next is the value `an` takes in that same edge. an_n therefore never lags `an`.
- scan_en 1->0: an and digit_idx freeze; an_n goes to 1111 on the next edge; no tick.
- scan_en 0->1: scanning resumes from the frozen cnt and digit. There is no restart.
- Reset mid-scan: next edge returns every register to its reset value, regardless of scan_en.
- `an` is never zero and never has more than one bit set, including out of reset. bcd7 depends on this for its priority decode.
- Full frame = 4 * 2**DIV_LOG2 cycles. At 100 MHz with DIV_LOG2=16 this is about 381 Hz.

Optional Feature:
- Macro: BCD7_SCAN_DIM_EN
- Defined:
  - vis = scan_en & (cnt[DIV_LOG2-1 -: 4] <= duty), evaluated on cnt_next.
  - Each digit is lit for (duty+1)/16 of its slot. duty=15 gives full brightness; duty=0 gives 1/16.
  - an, digit_idx and tick are unaffected.
- Undefined:
  - The duty port exists but is ignored.
  - vis = scan_en. Full brightness.

Decomposition:
- Shared package bcd7_pkg:
  - DIGITS = 4
  - AN_RESET = 4'b1000
  - AN_OFF_N = 4'b1111
  - typedef an_t (logic [3:0])
  - typedef digit_idx_t (logic [1:0])
  - bcd7 uses the same an_t.
- One sub-module, scan_prescaler:
  - Parameterised by DIV_LOG2.
  - Inputs clk, reset, en.
  - Outputs cnt and wrap (a combinational pulse, en & all-ones).
- bcd7_scan instantiates scan_prescaler and holds the ring, index, tick and an_n logic.

Test Plan (DIV_LOG2=4, so a 16-cycle slot):
- Reset, then scan_en=1 for 64 cycles -> an sequence 1000, 0100, 0010, 0001 with 16 cycles each, then back to 1000. tick is high in exactly 4 cycles, 16 apart. digit_idx follows 3, 2, 1, 0. an_n = ~an throughout.
- Right after reset, before any scan_en -> an = 1000, an_n = 1111, tick = 0, digit_idx = 3.
- scan_en dropped at cnt=7 in digit 0100 and held low 20 cycles -> an stays 0100, an_n = 1111, no tick. After re-enable, the advance to 0010 comes 8 cycles later.
- reset asserted for 1 cycle while an = 0010 and scan_en=1 -> next edge: an = 1000, cnt = 0, an_n = 1111. The following cycle an_n = 0111.
- BCD7_SCAN_DIM_EN, duty=3 -> in every slot an_n shows the digit low for 4 cycles (cnt 0..3) and 1111 for 12 cycles. duty=15 -> lit for all 16 cycles.
- BCD7_SCAN_DIM_EN undefined, duty=0 -> identical to full brightness (an_n = ~an every cycle).
